// File: rtl/led_pattern_sequencer.sv
// LED pattern engine: chase, bounce, fill and blink sequences advanced by a clock
// divider or a manual step pulse, with a per-pin polarity mask on the output bus.
module led_pattern_sequencer #(
    parameter int                  NUM_LEDS        = 10,
    parameter int                  STEP_DIV        = 3000000,
    parameter logic [NUM_LEDS-1:0] ACTIVE_LOW_MASK = {NUM_LEDS{1'b0}},
    parameter int                  BLANK_STEP      = 1
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic [1:0]                        mode,
    input  logic                              dir,
    input  logic                              run,
    input  logic                              step,
    output logic [NUM_LEDS-1:0]               led,
    output logic [$clog2(NUM_LEDS+1)-1:0]     pos,
    output logic                              wrap
);

    localparam int POS_W = $clog2(NUM_LEDS + 1);
    localparam int DIV_W = $clog2(STEP_DIV);

    localparam logic [1:0] MODE_CHASE  = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(STEP_DIV - 1);
    localparam logic [POS_W-1:0] CHASE_LAST  = POS_W'(NUM_LEDS + BLANK_STEP - 1);
    localparam logic [POS_W-1:0] BOUNCE_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0] FILL_LAST   = POS_W'(NUM_LEDS);
    localparam logic [POS_W-1:0] POS_ONE     = POS_W'(1);

    logic [DIV_W-1:0]    div_reg, div_next;
    logic [POS_W-1:0]    pos_reg, pos_next;
    logic                up_reg, up_next;
    logic                wrap_reg, wrap_next;
    logic [1:0]          mode_q_reg;
    logic                restart_reg;
    logic [NUM_LEDS-1:0] led_reg, pattern_next;
    logic [NUM_LEDS-1:0] onehot_pat, fill_pat;
    logic                restart, advance;

    // A mode change acts in the same cycle it is seen, so the new start step
    // is visible one clock later, exactly like a reset release.
    assign restart = restart_reg | (mode != mode_q_reg);
    assign advance = run ? (div_reg == DIV_LAST) : step;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_reg     <= '0;
            pos_reg     <= '0;
            up_reg      <= 1'b1;
            wrap_reg    <= 1'b0;
            mode_q_reg  <= MODE_CHASE;
            restart_reg <= 1'b1;
            led_reg     <= ACTIVE_LOW_MASK;
        end else begin
            div_reg     <= div_next;
            pos_reg     <= pos_next;
            up_reg      <= up_next;
            wrap_reg    <= wrap_next;
            mode_q_reg  <= mode;
            restart_reg <= 1'b0;
            led_reg     <= pattern_next ^ ACTIVE_LOW_MASK;
        end
    end

    always_comb begin
        div_next  = div_reg;
        pos_next  = pos_reg;
        up_next   = up_reg;
        wrap_next = 1'b0;
        if (restart) begin
            div_next = '0;
            pos_next = '0;
            up_next  = 1'b1;
        end else begin
            if (run) begin
                div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
            end
            if (advance) begin
                case (mode)
                    MODE_CHASE: begin
                        if (!dir) begin
                            pos_next = (pos_reg == CHASE_LAST) ? '0 : pos_reg + POS_ONE;
                        end else begin
                            pos_next = (pos_reg == '0) ? CHASE_LAST : pos_reg - POS_ONE;
                        end
                    end
                    MODE_BOUNCE: begin
                        if (NUM_LEDS == 1) begin
                            pos_next = '0;
                        end else if (up_reg) begin
                            pos_next = pos_reg + POS_ONE;
                            if (pos_next == BOUNCE_LAST) up_next = 1'b0;
                        end else begin
                            pos_next = pos_reg - POS_ONE;
                            if (pos_next == '0) up_next = 1'b1;
                        end
                    end
                    MODE_FILL: begin
                        pos_next = (pos_reg == FILL_LAST) ? '0 : pos_reg + POS_ONE;
                    end
                    default: begin
                        pos_next = (pos_reg == '0) ? POS_ONE : '0;
                    end
                endcase
                wrap_next = (pos_next == '0);
            end
        end
    end

    // Pattern bits are per-pin compares, so the blank step (pos == NUM_LEDS)
    // naturally decodes to all-dark without any out-of-range shift.
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_pat
        assign onehot_pat[gi] = (pos_next == POS_W'(gi));
        assign fill_pat[gi]   = (POS_W'(gi) < pos_next);
    end

    always_comb begin
        pattern_next = '0;
        case (mode)
            MODE_CHASE, MODE_BOUNCE: pattern_next = onehot_pat;
            MODE_FILL:               pattern_next = fill_pat;
            MODE_BLINK:              pattern_next = {NUM_LEDS{pos_next != '0}};
            default:                 pattern_next = '0;
        endcase
    end

    assign led  = led_reg;
    assign pos  = pos_reg;
    assign wrap = wrap_reg;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed scenarios plus randomized control,
// every cycle compared against a lap-index reference model.
module tb_led_pattern_sequencer;

    localparam int         N    = 4;
    localparam int         SD   = 4;
    localparam int         BL   = 1;
    localparam logic [3:0] MASK = 4'b0011;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       dir = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [3:0] led;
    logic [2:0] pos;
    logic       wrap;

    int checks = 0;
    int failures = 0;

    // Reference model: a lap index per mode, the step counter and the pending restart.
    logic [1:0] m_mode_q;
    bit         m_restart;
    int         m_cnt;
    int         m_k;
    bit         m_adv;
    logic [3:0] exp_led;
    int         exp_pos;
    bit         exp_wrap;

    always #5 CLK = ~CLK;

    led_pattern_sequencer #(
        .NUM_LEDS(N), .STEP_DIV(SD), .ACTIVE_LOW_MASK(MASK), .BLANK_STEP(BL)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .mode(mode), .dir(dir), .run(run), .step(step),
        .led(led), .pos(pos), .wrap(wrap)
    );

    function automatic int pos_of(logic [1:0] md, int k);
        if (md == 2'd1 && k >= N) return 2 * N - 2 - k;
        return k;
    endfunction

    function automatic logic [3:0] pattern_of(logic [1:0] md, int p);
        case (md)
            2'd0, 2'd1: return (p < N) ? 4'(1 << p) : 4'b0000;
            2'd2:       return 4'((1 << p) - 1);
            default:    return (p != 0) ? 4'b1111 : 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_mode_q  = 2'd0;
        m_restart = 1'b1;
        m_cnt     = 0;
        m_k       = 0;
        m_adv     = 1'b0;
        exp_led   = MASK;
        exp_pos   = 0;
        exp_wrap  = 1'b0;
    endtask

    task automatic model_edge();
        bit restart_now;
        bit adv;
        int per;
        restart_now = m_restart || (mode != m_mode_q);
        m_mode_q  = mode;
        m_restart = 1'b0;
        exp_wrap  = 1'b0;
        m_adv     = 1'b0;
        if (restart_now) begin
            m_cnt = 0;
            m_k   = 0;
        end else begin
            adv = run ? (m_cnt == SD - 1) : step;
            if (run) m_cnt = (m_cnt + 1) % SD;
            if (adv) begin
                case (mode)
                    2'd0:    per = N + BL;
                    2'd1:    per = (N > 1) ? 2 * N - 2 : 1;
                    2'd2:    per = N + 1;
                    default: per = 2;
                endcase
                if (mode == 2'd0 && dir) m_k = (m_k + per - 1) % per;
                else                     m_k = (m_k + 1) % per;
                exp_wrap = (pos_of(mode, m_k) == 0);
                m_adv    = 1'b1;
            end
        end
        exp_pos = pos_of(mode, m_k);
        exp_led = pattern_of(mode, exp_pos) ^ MASK;
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (RST_N) model_edge();
        #1;
        if (m_adv)
            $display("advance mode=%0d pos=%0d led=%b wrap=%0b", mode, pos, led, wrap);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; mode = 2'd0; dir = 1'b0; run = 1'b1; step = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if (led !== 4'b0011) begin failures++; $display("FAIL reset_led got=%b want=0011", led); end
        checks++;
        if (pos !== 3'd0) begin failures++; $display("FAIL reset_pos got=%0d want=0", pos); end
        checks++;
        if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b want=0", wrap); end
        RST_N = 1'b1;
        cycle();
        checks++;
        if (led !== 4'b0010) begin failures++; $display("FAIL first_lit led=%b want=0010", led); end
    endtask

    task automatic test_chase_up();
        dir = 1'b0; run = 1'b1;
        repeat (24) begin
            cycle();
            checks++;
            if ({led, pos, wrap} !== {exp_led, 3'(exp_pos), exp_wrap}) begin
                failures++;
                $display("FAIL chase_up led/pos/wrap=%b/%0d/%b want %b/%0d/%b",
                         led, pos, wrap, exp_led, exp_pos, exp_wrap);
            end
        end
    endtask

    task automatic test_chase_down();
        dir = 1'b1; run = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i >= 20 && $urandom_range(0, 7) == 0) dir = ~dir;
            cycle();
            checks++;
            if ({led, pos, wrap} !== {exp_led, 3'(exp_pos), exp_wrap}) begin
                failures++;
                $display("FAIL chase_dir led/pos/wrap=%b/%0d/%b want %b/%0d/%b",
                         led, pos, wrap, exp_led, exp_pos, exp_wrap);
            end
        end
    endtask

    task automatic test_bounce();
        mode = 2'd1; run = 1'b1;
        repeat (44) begin
            cycle();
            checks++;
            if ({led, pos, wrap} !== {exp_led, 3'(exp_pos), exp_wrap}) begin
                failures++;
                $display("FAIL bounce led/pos/wrap=%b/%0d/%b want %b/%0d/%b",
                         led, pos, wrap, exp_led, exp_pos, exp_wrap);
            end
        end
    endtask

    task automatic test_fill_step();
        mode = 2'd2; run = 1'b0;
        cycle();
        for (int i = 0; i < 6; i++) begin
            step = 1'b1;
            cycle();
            step = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                checks++;
                if ({led, pos, wrap} !== {exp_led, 3'(exp_pos), exp_wrap}) begin
                    failures++;
                    $display("FAIL fill_step led/pos/wrap=%b/%0d/%b want %b/%0d/%b",
                             led, pos, wrap, exp_led, exp_pos, exp_wrap);
                end
                cycle();
            end
        end
        checks++;
        if (led !== 4'b0010) begin failures++; $display("FAIL fill_six_steps led=%b want=0010", led); end
        run = 1'b1;
        repeat (20) begin
            step = ($urandom_range(0, 1) == 1);
            cycle();
            checks++;
            if ({led, pos, wrap} !== {exp_led, 3'(exp_pos), exp_wrap}) begin
                failures++;
                $display("FAIL fill_run_step led/pos/wrap=%b/%0d/%b want %b/%0d/%b",
                         led, pos, wrap, exp_led, exp_pos, exp_wrap);
            end
        end
        step = 1'b0;
    endtask

    task automatic test_mode_switch();
        int guard;
        mode = 2'd0; dir = 1'b0; run = 1'b1;
        cycle();
        cycle();
        guard = 0;
        while (m_cnt != SD - 1 && guard < 20) begin cycle(); guard++; end
        checks++;
        if (guard >= 20) begin failures++; $display("FAIL switch_wait timeout got=%0d want<20", guard); end
        mode = 2'd3;
        cycle();
        checks++;
        if ({led, pos, wrap} !== {MASK, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL switch_restart led/pos/wrap=%b/%0d/%b want 0011/0/0", led, pos, wrap);
        end
        repeat (3) begin
            cycle();
            checks++;
            if (led !== MASK) begin failures++; $display("FAIL switch_hold led=%b want=0011", led); end
        end
        cycle();
        checks++;
        if ({led, pos, wrap} !== {4'b1100, 3'd1, 1'b0}) begin
            failures++;
            $display("FAIL switch_first_blink led/pos/wrap=%b/%0d/%b want 1100/1/0", led, pos, wrap);
        end
    endtask

    task automatic test_async_reset();
        int guard;
        mode = 2'd1; run = 1'b1;
        guard = 0;
        cycle();
        while (exp_pos != 2 && guard < 60) begin cycle(); guard++; end
        checks++;
        if (pos !== 3'd2) begin failures++; $display("FAIL bounce_reach pos=%0d want=2", pos); end
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({led, pos, wrap} !== {MASK, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset led/pos/wrap=%b/%0d/%b want 0011/0/0", led, pos, wrap);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (30) begin
            cycle();
            checks++;
            if ({led, pos, wrap} !== {exp_led, 3'(exp_pos), exp_wrap}) begin
                failures++;
                $display("FAIL after_reset led/pos/wrap=%b/%0d/%b want %b/%0d/%b",
                         led, pos, wrap, exp_led, exp_pos, exp_wrap);
            end
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)  run  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) dir  = ~dir;
            step = ($urandom_range(0, 3) == 0);
            cycle();
            checks++;
            if ({led, pos, wrap} !== {exp_led, 3'(exp_pos), exp_wrap}) begin
                failures++;
                $display("FAIL random mode=%0d led/pos/wrap=%b/%0d/%b want %b/%0d/%b",
                         mode, led, pos, wrap, exp_led, exp_pos, exp_wrap);
            end
        end
        step = 1'b0;
    endtask

    initial begin
        test_reset();
        test_chase_up();
        test_chase_down();
        test_bounce();
        test_fill_step();
        test_mode_switch();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
